// File: rtl/beat_pkg.sv
// Shared beat-pipeline definitions: skid-buffer state encodings and pipeline-stage constants.
package beat_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      EMPTY = 2'd1,
      BUSY  = 2'd2,
      FULL  = 2'd3
   } beat_state_e;

   localparam int unsigned STAGE_IN   = 0;
   localparam int unsigned STAGE_OUT  = 1;
   localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/beat_stats_counter.sv
// Pop and stall counters for the beat skid buffer; both wrap modulo 2^CNT_W.
module beat_stats_counter
   import beat_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pop_i,
   input  logic             stall_i,
   output logic [CNT_W-1:0] beat_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      beat_d  = beat_q;
      stall_d = stall_q;
      if (pop_i)   beat_d  = beat_q + 1'b1;
      if (stall_i) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

   assign beat_cnt_o  = beat_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: rtl/beat_skid_buffer.sv
// Two-entry skid buffer with fully registered ready/valid/data outputs.
// Define BEAT_SKID_STATS_EN to add the beat_cnt/stall_cnt statistics outputs.
module beat_skid_buffer
   import beat_pkg::*;
#(
   parameter int unsigned DATA_W = 1,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              this_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              next_ready
`ifdef BEAT_SKID_STATS_EN
   ,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   beat_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              rdy_q, rdy_d;
   logic              vld_q, vld_d;
   logic              accept, pop;

   assign accept = in_valid && rdy_q;
   assign pop    = vld_q && next_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         INIT:  state_d = EMPTY;
         EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept && !pop) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (accept && pop) begin
               main_d  = in_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // rdy_q is low here, so in_valid cannot be accepted.
            if (pop) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: state_d = INIT;
      endcase
      // Handshake flags are decoded from the next state so they come straight from flops.
      rdy_d = (state_d == EMPTY) || (state_d == BUSY);
      vld_d = (state_d == BUSY)  || (state_d == FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
      end
   end

   assign this_ready = rdy_q;
   assign out_valid  = vld_q;
   assign out_data   = main_q;

`ifdef BEAT_SKID_STATS_EN
   beat_stats_counter #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .pop_i       (pop),
      .stall_i     (vld_q && !next_ready),
      .beat_cnt_o  (beat_cnt),
      .stall_cnt_o (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_beat_skid_buffer.sv
// Scoreboarded bench for beat_skid_buffer; stats scenario runs when BEAT_SKID_STATS_EN is defined.
module tb_beat_skid_buffer;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          this_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          next_ready;
`ifdef BEAT_SKID_STATS_EN
   logic [CW-1:0] beat_cnt;
   logic [CW-1:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] sb[$];

   beat_skid_buffer #(
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .this_ready (this_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .next_ready (next_ready)
`ifdef BEAT_SKID_STATS_EN
      ,
      .beat_cnt   (beat_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after posedge, so negedge sees what the next edge will see.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && next_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_ghost: got %h, expected no beat", out_data);
            end else begin
               logic [DW-1:0] exp;
               exp = sb.pop_front();
               if (out_data !== exp) begin
                  bad++;
                  $display("FAIL sb_data: got %h, expected %h", out_data, exp);
               end
            end
         end
         if (in_valid && this_ready) sb.push_back(in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h77; next_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (this_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_outs: got rdy=%b vld=%b data=%h, expected 0 0 00", this_ready, out_valid, out_data);
      end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (this_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_init: got rdy=%b vld=%b, expected 0 0", this_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (this_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_empty: got rdy=%b vld=%b, expected 1 0", this_ready, out_valid);
      end
   endtask

   task automatic test_stream();
      next_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         tick();
         total++;
         if (out_valid !== 1'b1 || this_ready !== 1'b1 || out_data !== DW'(i)) begin
            bad++;
            $display("FAIL stream_%0d: got vld=%b rdy=%b data=%h, expected 1 1 %h", i, out_valid, this_ready, out_data, DW'(i));
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0 || this_ready !== 1'b1) begin
         bad++;
         $display("FAIL stream_drain: got vld=%b rdy=%b, expected 0 1", out_valid, this_ready);
      end
   endtask

   task automatic test_backpressure();
      next_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h0A; tick();
      in_data = 8'h0B; tick();
      total++;
      if (this_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h0A) begin
         bad++;
         $display("FAIL bp_full: got rdy=%b vld=%b data=%h, expected 0 1 0a", this_ready, out_valid, out_data);
      end
      in_data = 8'h0C; tick();
      in_valid = 1'b0; in_data = 'x; tick();
      total++;
      if (this_ready !== 1'b0 || out_data !== 8'h0A) begin
         bad++;
         $display("FAIL bp_hold: got rdy=%b data=%h, expected 0 0a", this_ready, out_data);
      end
      in_valid = 1'b1; in_data = 8'h0C; next_ready = 1'b1; tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h0B || this_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_second: got vld=%b data=%h rdy=%b, expected 1 0b 1", out_valid, out_data, this_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_empty: got vld=%b, expected 0", out_valid);
      end
   endtask

   task automatic test_simul();
      next_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h05; tick();
      in_data = 8'h06; next_ready = 1'b1; tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || this_ready !== 1'b1 || out_data !== 8'h06) begin
         bad++;
         $display("FAIL simul: got vld=%b rdy=%b data=%h, expected 1 1 06", out_valid, this_ready, out_data);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      next_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h0D; tick();
      in_data = 8'h0E; tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || this_ready !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("FAIL midrst: got vld=%b rdy=%b data=%h, expected 0 0 00", out_valid, this_ready, out_data);
      end
      sb.delete();
      tick();
      rst_n = 1'b1;
      next_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ghost_%0d: got vld=%b data=%h, expected 0", i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_random();
      logic          pv, pn;
      logic [DW-1:0] pd;
      pv = 1'b0; pn = 1'b0; pd = '0;
      for (int i = 0; i < 80; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = DW'($urandom);
         next_ready = ($urandom_range(0, 3) != 0);
         pv = out_valid; pn = next_ready; pd = out_data;
         tick();
         if (pv && !pn) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== pd) begin
               bad++;
               $display("FAIL rand_stable_%0d: got vld=%b data=%h, expected 1 %h", i, out_valid, out_data, pd);
            end
         end
      end
      in_valid = 1'b0; next_ready = 1'b1;
      for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) tick();
      total++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rand_drain: got %0d pending vld=%b, expected 0 0", sb.size(), out_valid);
      end
   endtask

`ifdef BEAT_SKID_STATS_EN
   task automatic test_stats();
      in_valid = 1'b0; next_ready = 1'b1;
      rst_n = 1'b0; #1; sb.delete(); rst_n = 1'b1;
      tick();
      total++;
      if (beat_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
         bad++;
         $display("FAIL stats_reset: got beat=%0d stall=%0d, expected 0 0", beat_cnt, stall_cnt);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = DW'(8'h20 + i); tick();
      end
      in_valid = 1'b0; next_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      next_ready = 1'b1; tick();
      total++;
      if (beat_cnt !== 4'd10 || stall_cnt !== 4'd4) begin
         bad++;
         $display("FAIL stats_count: got beat=%0d stall=%0d, expected 10 4", beat_cnt, stall_cnt);
      end
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = DW'(8'h40 + i); tick();
      end
      in_valid = 1'b0; tick();
      total++;
      if (beat_cnt !== 4'd1 || stall_cnt !== 4'd4) begin
         bad++;
         $display("FAIL stats_wrap: got beat=%0d stall=%0d, expected 1 4", beat_cnt, stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_simul();
      test_mid_reset();
      test_random();
`ifdef BEAT_SKID_STATS_EN
      test_stats();
`endif
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beat_skid_buffer.md
BEAT_SKID_BUFFER -- requirements
Module: beat_skid_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 1, giving the payload width in bits.
REQ-002 SHALL provide parameter CNT_W, default 32, giving the statistics counter width (used only under REQ-030).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DATA_W  upstream payload.
REQ-006 in_valid  input  1  upstream payload is valid.
REQ-007 this_ready  output  1  registered; the block accepts in_data this cycle.
REQ-008 out_data  output  DATA_W  registered downstream payload.
REQ-009 out_valid  output  1  registered; out_data is valid.
REQ-010 next_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-011 SHALL define accept = in_valid && this_ready, and pop = out_valid && next_ready.
REQ-012 SHALL hold two storage entries, main (drives out_data) and skid, plus a state register with states INIT, EMPTY, BUSY and FULL.
REQ-013 SHALL drive this_ready, out_valid and out_data only from flops, with no combinational path from in_valid or next_ready to any output.
REQ-014 INIT SHALL move to EMPTY on the first rising edge after rst_n deasserts, with this_ready=0 and out_valid=0 while in INIT.
REQ-015 EMPTY SHALL have this_ready=1 and out_valid=0; on accept it SHALL load main<=in_data and move to BUSY.
REQ-016 BUSY SHALL have this_ready=1 and out_valid=1; on accept&&!pop it SHALL load skid<=in_data and move to FULL.
REQ-017 BUSY on pop&&!accept SHALL move to EMPTY; on accept&&pop it SHALL load main<=in_data and stay in BUSY.
REQ-018 FULL SHALL have this_ready=0 and out_valid=1; on pop it SHALL load main<=skid and move to BUSY, and SHALL ignore in_valid.
REQ-019 Latency from accept in EMPTY to out_valid SHALL be 1 cycle; sustained throughput with next_ready=1 SHALL be 1 beat per cycle.
REQ-020 SHALL deliver beats in order, with no loss and no duplication.
REQ-021 out_data SHALL remain stable while out_valid && !next_ready.
REQ-022 in_data SHALL be ignored whenever accept=0, including X values.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=INIT, this_ready=0, out_valid=0, out_data=0 and skid=0, including mid-transfer, discarding any stored beats.
REQ-024 No handshake SHALL complete while rst_n is low.

Configuration
REQ-030 When BEAT_SKID_STATS_EN is defined, the block SHALL add outputs beat_cnt[CNT_W] (count of pops) and stall_cnt[CNT_W] (count of cycles with out_valid && !next_ready).
REQ-031 Both counters SHALL reset to 0 and wrap modulo 2^CNT_W.
REQ-032 When BEAT_SKID_STATS_EN is undefined, these ports and counters SHALL be absent and datapath behaviour SHALL be identical.

Structure
REQ-040 State encodings (INIT=2'd0, EMPTY=2'd1, BUSY=2'd2, FULL=2'd3) SHALL live in the shared package/header beat_pkg, alongside the existing pipeline-stage constants.
REQ-041 The statistics counters SHALL be one sub-module, beat_stats_counter, instantiated only under BEAT_SKID_STATS_EN.

Verification
REQ-050 Reset release: after reset, this_ready is 0 for exactly one edge, then 1; out_valid is 0 throughout.
REQ-051 Streaming: feed 0x1,0x2,0x3 on back-to-back cycles with next_ready=1 -> out_data is 1,2,3 on consecutive cycles, 1 cycle after each accept; state stays BUSY.
REQ-052 Backpressure: next_ready=0 while feeding 0xA,0xB -> FULL, this_ready=0, out_data=0xA held; raise next_ready -> 0xA then 0xB, no loss; in_valid=1 with 0xC while FULL is not accepted.
REQ-053 Simultaneous accept and pop in BUSY: main=0x5 popped and 0x6 accepted in the same cycle -> next cycle out_data=0x6, state BUSY.
REQ-054 Mid-operation reset: assert rst_n low while FULL -> out_valid=0 and this_ready=0 immediately, without waiting for a clock; stored beats are never emitted.
REQ-055 Stats (BEAT_SKID_STATS_EN): 10 pops and 4 stall cycles -> beat_cnt=10, stall_cnt=4; with CNT_W=4, 17 pops -> beat_cnt=1.
